// File: rtl/dmem_unaligned_resp.sv
// Data-memory responder: byte/half/word load/store at any byte offset over word-wide byte-lane storage.
// Latency: 1 cycle for accesses within one word, 2 cycles for accesses crossing a word boundary.
// Backpressure: req_ready drops for the one SPLIT cycle of a crossing access; responses are never stalled.
//
// Ports:
//   clk, reset_b              clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (accept on valid & ready at posedge clk)
//   req_we, req_sz            1 = store; size 00 byte, 01 half, 10 word, 11 illegal
//   req_addr, req_wdata       byte address (any alignment), LSB-aligned store data
//   resp_valid                one-cycle pulse per accepted request, in order
//   resp_rdata, resp_err      LSB-aligned zero-extended load data; error flag for illegal size
module dmem_unaligned_resp #(
    parameter int DMEM_DEPTH = 1024,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_sz,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);
    localparam int WW = ADDR_WIDTH - 2;

    typedef enum logic {S_IDLE, S_SPLIT} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_mem [DMEM_DEPTH];

    // Request decode
    logic [WW-1:0]   w_widx;
    logic [1:0]      w_off;
    logic [3:0]      w_lane_mask;
    logic [31:0]     w_rmask;
    logic            w_illegal;
    logic            w_accept;
    logic            w_cross;
    logic [7:0]      w_be;
    logic [63:0]     w_wsh;
    logic [31:0]     w_lo_word;
    logic [31:0]     w_hi_word;
    logic [31:0]     w_split_rd;

    // Second-word context latched at the accept edge of a crossing access
    logic            r_we;
    logic [3:0]      r_hi_be;
    logic [31:0]     r_hi_dat;
    logic [WW-1:0]   r_widx_hi;
    logic [1:0]      r_off;
    logic [31:0]     r_rmask;
    logic [31:0]     r_lo_word;

    logic            r_resp_valid;
    logic [31:0]     r_resp_rdata;
    logic            r_resp_err;

    assign w_widx    = req_addr[ADDR_WIDTH-1:2];
    assign w_off     = req_addr[1:0];
    assign w_illegal = (req_sz == 2'b11);
    assign w_accept  = req_valid & req_ready;

    always_comb begin
        w_lane_mask = 4'b0000;
        w_rmask     = 32'h0000_0000;
        case (req_sz)
            2'b00: begin w_lane_mask = 4'b0001; w_rmask = 32'h0000_00FF; end
            2'b01: begin w_lane_mask = 4'b0011; w_rmask = 32'h0000_FFFF; end
            2'b10: begin w_lane_mask = 4'b1111; w_rmask = 32'hFFFF_FFFF; end
            default: ;
        endcase
    end

    // Byte enables and store data laid out over a two-word window starting at widx;
    // any enable in the upper half means the access spills into widx+1.
    assign w_be    = {4'b0000, w_lane_mask} << w_off;
    assign w_wsh   = {32'h0000_0000, req_wdata} << {w_off, 3'b000};
    assign w_cross = |w_be[7:4];

    assign w_lo_word  = r_mem[w_widx];
    assign w_hi_word  = r_mem[r_widx_hi];
    assign w_split_rd = 32'({w_hi_word, r_lo_word} >> {r_off, 3'b000});

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_accept && w_cross) w_state_nxt = S_SPLIT;
            end
            S_SPLIT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Storage: first word written at accept, second word in SPLIT. The two never coincide
    // because nothing is accepted during SPLIT. A reset during SPLIT drops the second write.
    always_ff @(posedge clk) begin
        if (w_accept && req_we) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) r_mem[w_widx][8*l +: 8] <= w_wsh[8*l +: 8];
            end
        end
        if (r_state == S_SPLIT && r_we) begin
            for (int l = 0; l < 4; l++) begin
                if (r_hi_be[l]) r_mem[r_widx_hi][8*l +: 8] <= r_hi_dat[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
            r_we         <= 1'b0;
            r_hi_be      <= 4'b0000;
            r_hi_dat     <= 32'h0000_0000;
            r_widx_hi    <= '0;
            r_off        <= 2'b00;
            r_rmask      <= 32'h0000_0000;
            r_lo_word    <= 32'h0000_0000;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_accept) begin
                if (w_cross) begin
                    r_we      <= req_we;
                    r_hi_be   <= w_be[7:4];
                    r_hi_dat  <= w_wsh[63:32];
                    r_widx_hi <= w_widx + {{(WW-1){1'b0}}, 1'b1};
                    r_off     <= w_off;
                    r_rmask   <= w_rmask;
                    r_lo_word <= w_lo_word;
                end else begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= w_illegal;
                    r_resp_rdata <= (req_we || w_illegal) ? 32'h0000_0000
                                  : ((w_lo_word >> {w_off, 3'b000}) & w_rmask);
                end
            end else if (r_state == S_SPLIT) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b0;
                r_resp_rdata <= r_we ? 32'h0000_0000 : (w_split_rd & r_rmask);
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
endmodule

// File: doc/dmem_unaligned_resp.md
# dmem_unaligned_resp

Data-memory responder for the RISC-V core's load/store port: the memory end of the access issued by the CPU (byte address, read/write, size code, write data). Serves byte, halfword and word accesses at any byte offset over a word-wide byte-lane storage array. An access that crosses a word boundary is split into two internal word cycles under a valid/ready handshake. Returned read data is LSB-aligned and zero-extended; sign extension stays in the CPU.

## Interface
Parameters:
- DMEM_DEPTH, 1024: number of 32-bit words in storage.
- ADDR_WIDTH, 12: byte address width; must equal log2(DMEM_DEPTH)+2.

Ports:
- clk  input  1  clock.
- reset_b  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid & req_ready at posedge clk.
- req_we  input  1  1 = store, 0 = load.
- req_sz  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_addr  input  ADDR_WIDTH  byte address, any alignment.
- req_wdata  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse, response/ack for the oldest accepted request.
- resp_rdata  output  32  load data, LSB-aligned, zero-extended; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid; 1 iff req_sz = 11.

## Operation
- Fields: widx = addr[ADDR_WIDTH-1:2], off = addr[1:0], nbytes = 1/2/4 for sz 00/01/10.
- Crossing iff off + nbytes > 4 (half at off 3; word at off 1..3). Second word index = widx+1 mod DMEM_DEPTH (top word wraps to word 0).
- Storage: DMEM_DEPTH x 4 byte lanes, per-lane write enable, no read-modify-write. Contents not reset.
- FSM states: IDLE, SPLIT.
  - IDLE: req_ready = 1. On accept of non-crossing or illegal request: stay IDLE. On accept of crossing legal request: latch request, go SPLIT.
  - SPLIT: req_ready = 0; perform second-word part; return to IDLE next edge.
- Store, non-crossing: lanes off..off+nbytes-1 of widx written with wdata bytes 0..nbytes-1 at the accept edge.
- Store, crossing: lanes off..3 of widx written at accept edge with low (4-off) bytes; lanes 0..(off+nbytes-5) of widx+1 written at the SPLIT edge with the remaining bytes.
- Load: concatenation {word[widx+1], word[widx]} shifted right by 8*off, masked to nbytes, upper bits zero. Low word sampled at accept edge, high word sampled in SPLIT.
- Illegal size: no storage effect, resp_err = 1, resp_rdata = 0.

## Timing
- Reset values: req_ready 1 (state IDLE), resp_valid 0, resp_rdata 0, resp_err 0; any latched request discarded.
- Non-crossing: accepted at edge T -> resp_valid high in cycle T+1; throughput one access per cycle, back-to-back allowed.
- Crossing: accepted at T -> req_ready low in cycle T+1, resp_valid in cycle T+2, req_ready high again in T+2.
- resp_rdata/resp_err registered; hold last value between pulses; no response backpressure.
- Read-after-write: a load accepted at the edge after a store's final write edge returns the new data (including a load accepted in the cycle a crossing store's response is out).
- Reset mid-SPLIT: second half aborted (first-half bytes of a crossing store remain written), no response issued, FSM returns to IDLE.
- Inputs ignored while req_ready = 0; requester holds the request stable until accepted.

## Test plan
- Word store 0xDEADBEEF @0x010, then back-to-back word load @0x010 -> resp_valid each cycle after accept, load rdata 0xDEADBEEF, resp_err 0.
- After above, byte load @0x013 -> 0x000000DE; half load @0x011 -> 0x0000ADBE; half load @0x012 -> 0x0000DEAD, all in 1 cycle.
- Crossing word store 0x11223344 @0x016 -> req_ready low one cycle, ack at T+2; word @0x014 upper half = 0x3344, word @0x018 lower half = 0x1122; word load @0x016 -> 0x11223344 at T+2 of its accept.
- Wrap: half store 0xA5B6 @0xFFF (ADDR_WIDTH 12) -> byte 0xFFF = 0xB6, byte 0x000 = 0xA5; half load @0xFFF -> 0x0000A5B6.
- req_sz = 11 store @0x020 data 0xFFFFFFFF -> resp_err 1, rdata 0, word @0x020 unchanged.
- Crossing word store 0xCAFEF00D @0x02D with reset_b low during SPLIT -> after release req_ready 1, resp_valid 0; bytes 0x02D-0x02F = 0x0D,0xF0,0xFE; byte 0x030 unchanged.
